// File: rtl/rf_sb_if.sv
// rf_sb_if: bundles the write, reservation, flush and read signals of rf_sb.
interface rf_sb_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_WR_PORTS  = 2
);
    localparam int AW = $clog2(NUM_REGISTERS);

    logic [NUM_WR_PORTS-1:0]            wr_en_in;
    logic [NUM_WR_PORTS*AW-1:0]         wr_addr_in;
    logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data_in;
    logic                               rsv_en_in;
    logic [AW-1:0]                      rsv_addr_in;
    logic                               flush_in;
    logic [AW-1:0]                      rs1_in;
    logic [AW-1:0]                      rs2_in;
    logic [DATA_WIDTH-1:0]              rs1_data_out;
    logic [DATA_WIDTH-1:0]              rs2_data_out;
    logic                               rs1_busy_out;
    logic                               rs2_busy_out;
    logic [AW:0]                        busy_cnt_out;

    // Pipeline side: drives writes, reservations, flush and read addresses.
    modport master (
        output wr_en_in, wr_addr_in, wr_data_in, rsv_en_in, rsv_addr_in, flush_in,
        output rs1_in, rs2_in,
        input  rs1_data_out, rs2_data_out, rs1_busy_out, rs2_busy_out, busy_cnt_out
    );

    // Register file side.
    modport slave (
        input  wr_en_in, wr_addr_in, wr_data_in, rsv_en_in, rsv_addr_in, flush_in,
        input  rs1_in, rs2_in,
        output rs1_data_out, rs2_data_out, rs1_busy_out, rs2_busy_out, busy_cnt_out
    );
endinterface

// File: rtl/rf_sb.sv
// rf_sb: multi-write-port integer register file with a pending-write (busy) scoreboard.
// Two combinational read ports, NUM_WR_PORTS writeback ports, one reservation port.
module rf_sb #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_WR_PORTS  = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input logic    clk,
    input logic    arst_n,
    rf_sb_if.slave bus
);
    localparam int AW = $clog2(NUM_REGISTERS);

    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] busy_q;
    logic [NUM_REGISTERS-1:0] busy_d;

    logic [NUM_WR_PORTS-1:0]  we;
    logic [AW-1:0]            wa [NUM_WR_PORTS];
    logic [DATA_WIDTH-1:0]    wd [NUM_WR_PORTS];
    logic                     rsv_ok;

    logic [AW-1:0]            rd_addr [2];
    logic [DATA_WIDTH-1:0]    rd_data [2];
    logic                     rd_busy [2];
    logic [AW:0]              cnt;

    // Unpack write ports; writes to a hardwired-zero register are dropped here.
    always_comb begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            wa[p] = bus.wr_addr_in[p*AW +: AW];
            wd[p] = bus.wr_data_in[p*DATA_WIDTH +: DATA_WIDTH];
            we[p] = bus.wr_en_in[p] && !((ZERO_REG != 0) && (wa[p] == '0));
        end
        rsv_ok = bus.rsv_en_in && !((ZERO_REG != 0) && (bus.rsv_addr_in == '0));
    end

    // Next register data: later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (we[p]) begin
                regs_d[wa[p]] = wd[p];
            end
        end
    end

    // Next busy vector: writes clear, reservation overrides writes, flush overrides all.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (we[p]) begin
                busy_d[wa[p]] = 1'b0;
            end
        end
        if (rsv_ok) begin
            busy_d[bus.rsv_addr_in] = 1'b1;
        end
        if (bus.flush_in) begin
            busy_d = '0;
        end
    end

    // Register and scoreboard state, cleared asynchronously.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value, optionally overridden by same-cycle write data.
    always_comb begin
        rd_addr[0] = bus.rs1_in;
        rd_addr[1] = bus.rs2_in;
        for (int r = 0; r < 2; r++) begin
            rd_data[r] = regs_q[rd_addr[r]];
            rd_busy[r] = busy_q[rd_addr[r]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    if (we[p] && (wa[p] == rd_addr[r])) begin
                        rd_data[r] = wd[p];
                        rd_busy[r] = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[r] == '0)) begin
                rd_data[r] = '0;
                rd_busy[r] = 1'b0;
            end
        end
    end

    // Population count of the registered busy vector.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            cnt = cnt + (AW+1)'(busy_q[i]);
        end
    end

    // Drive interface outputs.
    always_comb begin
        bus.rs1_data_out = rd_data[0];
        bus.rs2_data_out = rd_data[1];
        bus.rs1_busy_out = rd_busy[0];
        bus.rs2_busy_out = rd_busy[1];
        bus.busy_cnt_out = cnt;
    end
endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: directed bench for rf_sb. Instance a: BYPASS=0, ZERO_REG=0.
// Instance b: BYPASS=1, ZERO_REG=1. Both receive identical stimulus.
module tb_rf_sb;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NW = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    rf_sb_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_WR_PORTS(NW)) ifa ();
    rf_sb_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_WR_PORTS(NW)) ifb ();

    rf_sb #(
        .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_WR_PORTS(NW), .ZERO_REG(0), .BYPASS(0)
    ) u_a (
        .clk(clk), .arst_n(arst_n), .bus(ifa)
    );

    rf_sb #(
        .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_WR_PORTS(NW), .ZERO_REG(1), .BYPASS(1)
    ) u_b (
        .clk(clk), .arst_n(arst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifa.wr_en_in = '0; ifa.wr_addr_in = '0; ifa.wr_data_in = '0;
        ifa.rsv_en_in = 1'b0; ifa.rsv_addr_in = '0; ifa.flush_in = 1'b0;
        ifb.wr_en_in = '0; ifb.wr_addr_in = '0; ifb.wr_data_in = '0;
        ifb.rsv_en_in = 1'b0; ifb.rsv_addr_in = '0; ifb.flush_in = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifa.wr_en_in[p] = 1'b1; ifa.wr_addr_in[p*AW +: AW] = a; ifa.wr_data_in[p*DW +: DW] = d;
        ifb.wr_en_in[p] = 1'b1; ifb.wr_addr_in[p*AW +: AW] = a; ifb.wr_data_in[p*DW +: DW] = d;
    endtask

    task automatic set_rsv(input logic [AW-1:0] a);
        ifa.rsv_en_in = 1'b1; ifa.rsv_addr_in = a;
        ifb.rsv_en_in = 1'b1; ifb.rsv_addr_in = a;
    endtask

    task automatic set_flush();
        ifa.flush_in = 1'b1; ifb.flush_in = 1'b1;
    endtask

    task automatic set_rs(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        ifa.rs1_in = r1; ifa.rs2_in = r2;
        ifb.rs1_in = r1; ifb.rs2_in = r2;
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_rs(5'd1, 5'd2);
        #2;
        // Reset state
        chk("rst_a_d1", ifa.rs1_data_out, 0);
        chk("rst_b_d1", ifb.rs1_data_out, 0);
        chk("rst_a_cnt", ifa.busy_cnt_out, 0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();

        // Basic write port0 addr 5
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_rs(5'd5, 5'd0);
        #1;
        chk("wr_a_same_cycle_old", ifa.rs1_data_out, 0);
        chk("wr_b_same_cycle_byp", ifb.rs1_data_out, 32'hDEADBEEF);
        chk("wr_b_byp_busy", ifb.rs1_busy_out, 0);
        tick();
        idle();
        #1;
        chk("wr_a_after", ifa.rs1_data_out, 32'hDEADBEEF);
        chk("wr_b_after", ifb.rs1_data_out, 32'hDEADBEEF);

        // Bypass via port1 addr 7
        set_wr(1, 5'd7, 32'h1234);
        set_rs(5'd5, 5'd7);
        #1;
        chk("byp_b_rs2", ifb.rs2_data_out, 32'h1234);
        chk("byp_b_rs2_busy", ifb.rs2_busy_out, 0);
        chk("byp_a_rs2_old", ifa.rs2_data_out, 0);
        tick();
        idle();
        #1;
        chk("byp_a_stored", ifa.rs2_data_out, 32'h1234);
        chk("byp_b_stored", ifb.rs2_data_out, 32'h1234);

        // Port conflict on addr 3: highest port wins
        set_wr(0, 5'd3, 32'hAAAA);
        set_wr(1, 5'd3, 32'hBBBB);
        set_rs(5'd3, 5'd7);
        #1;
        chk("conf_b_byp", ifb.rs1_data_out, 32'hBBBB);
        tick();
        idle();
        #1;
        chk("conf_a_stored", ifa.rs1_data_out, 32'hBBBB);
        chk("conf_b_stored", ifb.rs1_data_out, 32'hBBBB);

        // Scoreboard: reserve 9
        set_rsv(5'd9);
        set_rs(5'd9, 5'd10);
        #1;
        chk("rsv_a_pre_busy", ifa.rs1_busy_out, 0);
        tick();
        idle();
        #1;
        chk("rsv_a_busy", ifa.rs1_busy_out, 1);
        chk("rsv_b_busy", ifb.rs1_busy_out, 1);
        chk("rsv_a_cnt", ifa.busy_cnt_out, 1);
        chk("rsv_b_cnt", ifb.busy_cnt_out, 1);

        // Reserve 9 and write 9 together: reservation wins, data written
        set_rsv(5'd9);
        set_wr(0, 5'd9, 32'h99);
        #1;
        chk("rsvwr_b_byp_busy", ifb.rs1_busy_out, 0);
        chk("rsvwr_b_byp_data", ifb.rs1_data_out, 32'h99);
        chk("rsvwr_a_pre_busy", ifa.rs1_busy_out, 1);
        tick();
        idle();
        #1;
        chk("rsvwr_a_busy", ifa.rs1_busy_out, 1);
        chk("rsvwr_a_data", ifa.rs1_data_out, 32'h99);
        chk("rsvwr_b_cnt", ifb.busy_cnt_out, 1);

        // Write 9 alone clears busy
        set_wr(1, 5'd9, 32'h55);
        tick();
        idle();
        #1;
        chk("clr_a_busy", ifa.rs1_busy_out, 0);
        chk("clr_a_cnt", ifa.busy_cnt_out, 0);
        chk("clr_b_cnt", ifb.busy_cnt_out, 0);
        chk("clr_a_data", ifa.rs1_data_out, 32'h55);

        // Reserve 4 and 6, then flush with a reservation and a write
        set_rsv(5'd4);
        tick();
        set_rsv(5'd6);
        tick();
        idle();
        set_rs(5'd4, 5'd6);
        #1;
        chk("rsv46_a_cnt", ifa.busy_cnt_out, 2);
        chk("rsv46_b_busy2", ifb.rs2_busy_out, 1);
        set_flush();
        set_rsv(5'd10);
        set_wr(0, 5'd11, 32'h77);
        tick();
        idle();
        set_rs(5'd11, 5'd10);
        #1;
        chk("flush_a_cnt", ifa.busy_cnt_out, 0);
        chk("flush_b_cnt", ifb.busy_cnt_out, 0);
        chk("flush_a_rsv_lost", ifa.rs2_busy_out, 0);
        chk("flush_a_wr_data", ifa.rs1_data_out, 32'h77);

        // Zero register: write and reserve addr 0
        set_wr(0, 5'd0, 32'hFFFF);
        set_rsv(5'd0);
        set_rs(5'd0, 5'd5);
        #1;
        chk("zero_b_pre_data", ifb.rs1_data_out, 0);
        chk("zero_b_pre_busy", ifb.rs1_busy_out, 0);
        tick();
        idle();
        #1;
        chk("zero_b_data", ifb.rs1_data_out, 0);
        chk("zero_b_busy", ifb.rs1_busy_out, 0);
        chk("zero_b_cnt", ifb.busy_cnt_out, 0);
        chk("zero_a_data", ifa.rs1_data_out, 32'hFFFF);
        chk("zero_a_busy", ifa.rs1_busy_out, 1);
        chk("zero_a_cnt", ifa.busy_cnt_out, 1);
        chk("pre_rst_a_rs2", ifa.rs2_data_out, 32'hDEADBEEF);

        // Asynchronous reset between edges
        #1;
        arst_n = 1'b0;
        #1;
        chk("arst_a_rs1", ifa.rs1_data_out, 0);
        chk("arst_a_busy", ifa.rs1_busy_out, 0);
        chk("arst_a_rs2", ifa.rs2_data_out, 0);
        chk("arst_a_cnt", ifa.busy_cnt_out, 0);
        chk("arst_b_rs2", ifb.rs2_data_out, 0);
        tick();
        arst_n = 1'b1;
        tick();
        chk("post_rst_b_rs2", ifb.rs2_data_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
